// File: rtl/fifoctrl_pkg.sv
// fifoctrl_pkg: shared definitions for the parametrised sync FIFO controller.
//   - DEF_* : default parameter values used by the modules
//   - DEF_CNT_W : occupancy counter width (ADDRBIT+1) for the default build
//   - count_w() : occupancy counter width for any ADDRBIT
//   - ptr_next() : pointer increment with wrap at depth-1 (depth need not be 2^n)
//   - params_ok() : parameter legality check used at elaboration
package fifoctrl_pkg;

  localparam int unsigned DEF_ADDRBIT   = 5;
  localparam int unsigned DEF_DEPTH     = 32;
  localparam int unsigned DEF_AFULL_TH  = 28;
  localparam int unsigned DEF_AEMPTY_TH = 4;

  function automatic int unsigned count_w(input int unsigned addrbit);
    return addrbit + 1;
  endfunction

  localparam int unsigned DEF_CNT_W = count_w(DEF_ADDRBIT);

  function automatic int unsigned ptr_next(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  function automatic bit params_ok(input int unsigned addrbit,
                                   input int unsigned depth,
                                   input int unsigned afull_th,
                                   input int unsigned aempty_th);
    return (depth >= 2) && (depth <= (1 << addrbit)) &&
           (afull_th >= 1) && (afull_th <= depth) &&
           (aempty_th <= depth - 1);
  endfunction

endpackage

// File: rtl/fifoctrl_sync_param_if.sv
// fifoctrl_sync_param_if: producer/consumer + RAM port bundle of the FIFO controller.
//   master : request side (drives fifowr, fiford, clr; observes everything else)
//   slave  : controller side (drives RAM enables/addresses, rdvalid, flags, fifolen, ovf/udf)
interface fifoctrl_sync_param_if
  import fifoctrl_pkg::*;
#(
  parameter int unsigned ADDRBIT = DEF_ADDRBIT
);
  logic               fifowr;
  logic               fiford;
  logic               clr;
  logic               write;
  logic [ADDRBIT-1:0] wraddr;
  logic               read;
  logic [ADDRBIT-1:0] rdaddr;
  logic               rdvalid;
  logic               fifofull;
  logic               notempty;
  logic               almostfull;
  logic               almostempty;
  logic [ADDRBIT:0]   fifolen;
  logic               ovf;
  logic               udf;

  modport master (
    output fifowr, fiford, clr,
    input  write, wraddr, read, rdaddr, rdvalid,
    input  fifofull, notempty, almostfull, almostempty, fifolen, ovf, udf
  );

  modport slave (
    input  fifowr, fiford, clr,
    output write, wraddr, read, rdaddr, rdvalid,
    output fifofull, notempty, almostfull, almostempty, fifolen, ovf, udf
  );
endinterface

// File: rtl/fifoctrl_wrapptr.sv
// fifoctrl_wrapptr: ADDRBIT-bit pointer that wraps from DEPTH-1 to 0.
//   clkw : clock            rst : synchronous reset, active-low
//   clr  : synchronous clear, active-high, wins over inc
//   inc  : advance pointer  ptr : current pointer value
module fifoctrl_wrapptr
  import fifoctrl_pkg::*;
#(
  parameter int unsigned ADDRBIT = DEF_ADDRBIT,
  parameter int unsigned DEPTH   = DEF_DEPTH
) (
  input  logic               clkw,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [ADDRBIT-1:0] ptr
);

  always_ff @(posedge clkw) begin
    if (!rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ADDRBIT'(ptr_next(32'(ptr), DEPTH));
    end
  end

endmodule

// File: rtl/fifoctrl_sync_param.sv
// fifoctrl_sync_param: single-clock FIFO controller for an external 2-port RAM
// with 1-cycle read latency. Depth need not be a power of two.
//   clkw : clock             rst : synchronous reset, active-low
//   bus  : fifoctrl_sync_param_if.slave (requests, RAM port, flags, fifolen, ovf/udf)
// Optional build macro FIFOCTRL_ERRFLAG_EN: sticky ovf/udf flags; without it
// both outputs are tied to 0.
module fifoctrl_sync_param
  import fifoctrl_pkg::*;
#(
  parameter int unsigned ADDRBIT   = DEF_ADDRBIT,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned AFULL_TH  = DEF_AFULL_TH,
  parameter int unsigned AEMPTY_TH = DEF_AEMPTY_TH
) (
  input  logic                clkw,
  input  logic                rst,
  fifoctrl_sync_param_if.slave bus
);

  localparam int unsigned CNT_W = count_w(ADDRBIT);

  if (!params_ok(ADDRBIT, DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
    $error("fifoctrl_sync_param: illegal ADDRBIT/DEPTH/AFULL_TH/AEMPTY_TH combination");
  end

  logic [CNT_W-1:0] fifolen;
  logic             fifofull;
  logic             notempty;
  logic             write;
  logic             read;
  logic             rdvalid;

  // Flags come only from the registered count: no same-cycle bypass between
  // a write and a read, so empty refuses reads and full refuses writes.
  assign fifofull = (fifolen == CNT_W'(DEPTH));
  assign notempty = (fifolen != '0);
  assign write    = bus.fifowr & ~fifofull & ~bus.clr;
  assign read     = bus.fiford & notempty & ~bus.clr;

  fifoctrl_wrapptr #(.ADDRBIT(ADDRBIT), .DEPTH(DEPTH)) u_wrptr (
    .clkw (clkw),
    .rst  (rst),
    .clr  (bus.clr),
    .inc  (write),
    .ptr  (bus.wraddr)
  );

  fifoctrl_wrapptr #(.ADDRBIT(ADDRBIT), .DEPTH(DEPTH)) u_rdptr (
    .clkw (clkw),
    .rst  (rst),
    .clr  (bus.clr),
    .inc  (read),
    .ptr  (bus.rdaddr)
  );

  always_ff @(posedge clkw) begin
    if (!rst || bus.clr) begin
      fifolen <= '0;
      rdvalid <= 1'b0;
    end else begin
      rdvalid <= read;
      case ({read, write})
        2'b01:   fifolen <= fifolen + 1'b1;
        2'b10:   fifolen <= fifolen - 1'b1;
        default: fifolen <= fifolen;
      endcase
    end
  end

`ifdef FIFOCTRL_ERRFLAG_EN
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge clkw) begin
    if (!rst || bus.clr) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.fifowr && fifofull) ovf_q <= 1'b1;
      if (bus.fiford && !notempty) udf_q <= 1'b1;
    end
  end

  assign bus.ovf = ovf_q;
  assign bus.udf = udf_q;
`else
  assign bus.ovf = 1'b0;
  assign bus.udf = 1'b0;
`endif

  assign bus.write       = write;
  assign bus.read        = read;
  assign bus.rdvalid     = rdvalid;
  assign bus.fifolen     = fifolen;
  assign bus.fifofull    = fifofull;
  assign bus.notempty    = notempty;
  assign bus.almostfull  = (fifolen >= CNT_W'(AFULL_TH));
  assign bus.almostempty = (fifolen <= CNT_W'(AEMPTY_TH));

endmodule

// File: tb/tb_fifoctrl_sync_param.sv
// tb_fifoctrl_sync_param: directed bench for fifoctrl_sync_param.
// Instance u_dut24: DEPTH=24 (non power of two), AFULL_TH=20, AEMPTY_TH=4,
// with a behavioural 1-cycle-latency RAM and a data-order scoreboard.
// Instance u_dut32: default parameters, used for reset/idle and the 2^ADDRBIT fill.
module tb_fifoctrl_sync_param;
  import fifoctrl_pkg::*;

  localparam int D24 = 24;
  localparam int AF24 = 20;
  localparam int AE24 = 4;

  logic clkw = 1'b0;
  logic rst24, rst32;
  always #5 clkw = ~clkw;

  fifoctrl_sync_param_if #(.ADDRBIT(5)) b24 ();
  fifoctrl_sync_param_if #(.ADDRBIT(5)) b32 ();

  fifoctrl_sync_param #(.ADDRBIT(5), .DEPTH(24), .AFULL_TH(20), .AEMPTY_TH(4)) u_dut24 (
    .clkw (clkw),
    .rst  (rst24),
    .bus  (b24.slave)
  );

  fifoctrl_sync_param u_dut32 (
    .clkw (clkw),
    .rst  (rst32),
    .bus  (b32.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // reference state for the DEPTH=24 instance
  int          m_len = 0, m_wp = 0, m_rp = 0;
  bit          m_rv = 0, m_ovf = 0, m_udf = 0;
  logic [15:0] ram [0:31];
  logic [15:0] q [$];
  logic [15:0] wdata = 16'h100;
  logic [15:0] rdata, exp_data;

  task automatic cyc24(input bit wr, input bit rd, input bit cl, input bit rs);
    bit e_wr, e_rd, did_rd;
    logic [15:0] cap;
    b24.fifowr = wr; b24.fiford = rd; b24.clr = cl; rst24 = rs;
    #1;
    e_wr = wr && (m_len != D24) && !cl;
    e_rd = rd && (m_len != 0) && !cl;
    chk("write", b24.write, e_wr);
    chk("read", b24.read, e_rd);
    chk("wraddr", b24.wraddr, m_wp);
    chk("rdaddr", b24.rdaddr, m_rp);
    chk("fifolen", b24.fifolen, m_len);
    chk("fifofull", b24.fifofull, m_len == D24);
    chk("notempty", b24.notempty, m_len != 0);
    chk("almostfull", b24.almostfull, m_len >= AF24);
    chk("almostempty", b24.almostempty, m_len <= AE24);
    // RAM port behaviour, driven by the DUT's own enables/addresses
    did_rd = b24.read;
    cap = ram[b24.rdaddr];
    if (b24.write) ram[b24.wraddr] = wdata;
    if (!rs || cl) begin
      m_len = 0; m_wp = 0; m_rp = 0; m_rv = 0; m_ovf = 0; m_udf = 0;
      q.delete();
    end else begin
`ifdef FIFOCTRL_ERRFLAG_EN
      if (wr && m_len == D24) m_ovf = 1;
      if (rd && m_len == 0) m_udf = 1;
`endif
      if (e_wr) begin
        q.push_back(wdata);
        m_wp = (m_wp == D24 - 1) ? 0 : m_wp + 1;
      end
      if (e_rd) begin
        exp_data = q.pop_front();
        m_rp = (m_rp == D24 - 1) ? 0 : m_rp + 1;
      end
      m_len = m_len + int'(e_wr) - int'(e_rd);
      m_rv = e_rd;
    end
    if (e_wr) wdata++;
    @(posedge clkw);
    if (did_rd) rdata = cap;
    #1;
    chk("rdvalid", b24.rdvalid, m_rv);
    if (m_rv) chk("rdata", rdata, exp_data);
    chk("ovf", b24.ovf, m_ovf);
    chk("udf", b24.udf, m_udf);
  endtask

  initial begin
    b24.fifowr = 0; b24.fiford = 0; b24.clr = 0;
    b32.fifowr = 0; b32.fiford = 0; b32.clr = 0;
    rst24 = 0; rst32 = 0;
    repeat (2) @(posedge clkw);
    #1;
    rst24 = 1; rst32 = 1;

    // DEPTH=32 reset/idle state
    chk("r32_fifolen", b32.fifolen, 0);
    chk("r32_notempty", b32.notempty, 0);
    chk("r32_almostempty", b32.almostempty, 1);
    chk("r32_almostfull", b32.almostfull, 0);
    chk("r32_fifofull", b32.fifofull, 0);
    chk("r32_wraddr", b32.wraddr, 0);
    chk("r32_rdaddr", b32.rdaddr, 0);
    chk("r32_rdvalid", b32.rdvalid, 0);
    chk("r32_ovf", b32.ovf, 0);
    chk("r32_udf", b32.udf, 0);

    // DEPTH=32: fill to 2^ADDRBIT, count must reach 32 in a 6-bit field
    b32.fifowr = 1;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clkw); #1;
      if (i == 27) chk("f32_afull_27", b32.almostfull, 0);
      if (i == 28) chk("f32_afull_28", b32.almostfull, 1);
      if (i == 31) chk("f32_full_31", b32.fifofull, 0);
    end
    chk("f32_fifolen", b32.fifolen, 32);
    chk("f32_fifofull", b32.fifofull, 1);
    chk("f32_wraddr_wrap", b32.wraddr, 0);
    chk("f32_write_refused", b32.write, 0);
    @(posedge clkw); #1;
    chk("f32_fifolen_hold", b32.fifolen, 32);
    b32.fifowr = 0;

    // DEPTH=24: idle after reset
    cyc24(0, 0, 0, 1);
    chk("r24_almostempty", b24.almostempty, 1);

    // 24 writes to full, then a refused 25th write
    for (int i = 0; i < 24; i++) cyc24(1, 0, 0, 1);
    chk("w24_fifolen", b24.fifolen, 24);
    chk("w24_fifofull", b24.fifofull, 1);
    chk("w24_almostfull", b24.almostfull, 1);
    cyc24(1, 0, 0, 1);
    chk("w25_fifolen", b24.fifolen, 24);
`ifdef FIFOCTRL_ERRFLAG_EN
    chk("w25_ovf", b24.ovf, 1);
`else
    chk("w25_ovf", b24.ovf, 0);
`endif

    // simultaneous at full: only the read is accepted
    cyc24(1, 1, 0, 1);
    chk("sim_full_fifolen", b24.fifolen, 23);

    // continuous traffic: both pointers run through the 23->0 wrap
    for (int i = 0; i < 30; i++) cyc24(1, 1, 0, 1);
    chk("cont_fifolen", b24.fifolen, 23);
    // drain to empty, then one read on empty
    for (int i = 0; i < 23; i++) cyc24(0, 1, 0, 1);
    chk("drain_fifolen", b24.fifolen, 0);
    cyc24(0, 1, 0, 1);

    // flush clears sticky flags, then simultaneous at empty: only the write
    cyc24(0, 0, 1, 1);
    cyc24(1, 1, 0, 1);
    chk("sim_empty_fifolen", b24.fifolen, 1);
`ifdef FIFOCTRL_ERRFLAG_EN
    chk("sim_empty_udf", b24.udf, 1);
`else
    chk("sim_empty_udf", b24.udf, 0);
`endif

    // simultaneous at fifolen=5
    for (int i = 0; i < 4; i++) cyc24(1, 0, 0, 1);
    cyc24(1, 1, 0, 1);
    chk("sim5_fifolen", b24.fifolen, 5);
    chk("sim5_rdvalid", b24.rdvalid, 1);

    // clr at fifolen=10 together with fifowr and fiford
    for (int i = 0; i < 5; i++) cyc24(1, 0, 0, 1);
    chk("pre_clr_fifolen", b24.fifolen, 10);
    cyc24(1, 1, 1, 1);
    chk("clr_fifolen", b24.fifolen, 0);
    chk("clr_wraddr", b24.wraddr, 0);
    chk("clr_rdaddr", b24.rdaddr, 0);
    chk("clr_rdvalid", b24.rdvalid, 0);

    // reset at fifolen=17 with a read in the prior cycle
    for (int i = 0; i < 18; i++) cyc24(1, 0, 0, 1);
    cyc24(0, 1, 0, 1);
    chk("pre_rst_fifolen", b24.fifolen, 17);
    chk("pre_rst_rdvalid", b24.rdvalid, 1);
    cyc24(0, 1, 0, 0);
    chk("rst_fifolen", b24.fifolen, 0);
    chk("rst_rdvalid", b24.rdvalid, 0);
    chk("rst_wraddr", b24.wraddr, 0);
    chk("rst_rdaddr", b24.rdaddr, 0);
    cyc24(0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifoctrl_sync_param.md
Name: fifoctrl_sync_param

Overview:
Single-clock, parametrised FIFO controller. It is the next generation of the team's two-port-memory FIFO controller. It drives the write and read ports of an external 2-port RAM with depth DEPTH, and that depth need not be a power of two. It keeps an exact occupancy count and adds programmable almost-full/almost-empty watermarks, a synchronous flush and a read-data-valid strobe. It sits between a producer/consumer pair and a RAM that has 1-cycle read latency.

Parameters:
ADDRBIT, 5, RAM address width; must satisfy 2^ADDRBIT >= DEPTH.
DEPTH, 32, number of entries; legal range 2..2^ADDRBIT.
AFULL_TH, 28, almostfull asserts when fifolen >= AFULL_TH; legal range 1..DEPTH.
AEMPTY_TH, 4, almostempty asserts when fifolen <= AEMPTY_TH; legal range 0..DEPTH-1.

Ports:
clkw  in  1  single clock for all logic
rst  in  1  synchronous, active-low reset
fifowr  in  1  write request
fiford  in  1  read request
clr  in  1  synchronous flush, active-high
write  out  1  RAM write enable
wraddr  out  ADDRBIT  RAM write address
read  out  1  RAM read enable
rdaddr  out  ADDRBIT  RAM read address
rdvalid  out  1  RAM read data valid; registered, 1 cycle after read
fifofull  out  1  fifolen == DEPTH
notempty  out  1  fifolen != 0
almostfull  out  1  fifolen >= AFULL_TH
almostempty  out  1  fifolen <= AEMPTY_TH
fifolen  out  ADDRBIT+1  occupancy, 0..DEPTH
ovf  out  1  sticky overflow flag (optional feature)
udf  out  1  sticky underflow flag (optional feature)

Behaviour:
- Reset: rst is synchronous and active-low; clock is clkw. On the first clkw edge with rst=0:
  - wrptr=0, rdptr=0, fifolen=0, rdvalid=0, ovf=0, udf=0.
  - Resulting outputs: fifofull=0, notempty=0, almostfull=0, almostempty=1.
- Reset mid-operation discards all contents. No outstanding rdvalid is emitted after the reset edge.
- Enables (combinational):
  - write = fifowr & !fifofull & !clr
  - read = fiford & notempty & !clr
- Flags are derived only from the registered fifolen. There is no bypass:
  - A read on an empty FIFO is refused even if a write occurs in the same cycle.
  - A write on a full FIFO is refused even if a read occurs in the same cycle.
- wraddr=wrptr, rdaddr=rdptr.
- Each pointer increments on its enable and wraps from DEPTH-1 to 0. There is no power-of-two wrap.
- fifolen update by {read, write}:
  - 01: +1
  - 10: -1
  - 11: unchanged, both pointers advance
  - 00: hold
- fifolen is an (ADDRBIT+1)-bit count, so fifolen=DEPTH=2^ADDRBIT is representable.
- rdvalid <= read every cycle. RAM data is sampled by the consumer when rdvalid=1.
- clr=1 (rst=1): next edge sets wrptr=0, rdptr=0, fifolen=0, ovf=0, udf=0 and rdvalid=0. clr has priority over fifowr/fiford in the same cycle.
- All flag outputs are combinational from fifolen, so they change 1 cycle after the accepted operation.

Optional Feature:
- Macro: FIFOCTRL_ERRFLAG_EN.
- Defined:
  - ovf sets (sticky) on any edge where fifowr=1, fifofull=1, clr=0.
  - udf sets (sticky) on any edge where fiford=1, notempty=0, clr=0.
  - Both clear only on rst or clr.
- Not defined: ovf and udf ports remain present and are tied to 0, so the interface is unchanged.

Decomposition:
- Package fifoctrl_pkg holds:
  - ptr_next function (increment with wrap at DEPTH-1).
  - Parameter legality checks (elaboration-time assertions on DEPTH, AFULL_TH, AEMPTY_TH).
  - Localparam for the count width ADDRBIT+1.
- One sub-module, fifoctrl_wrapptr: ADDRBIT-bit wrapping counter with inc, clr and rst inputs. It is instantiated twice, for the write pointer and the read pointer.

Test Plan:
- Reset then idle (DEPTH=32): fifolen=0, notempty=0, almostempty=1, fifofull=0, wraddr=rdaddr=0, rdvalid=0.
- DEPTH=24, ADDRBIT=5, 24 writes:
  - fifofull=1 after write 24; almostfull=1 from fifolen=AFULL_TH.
  - 25th fifowr gives write=0, fifolen stays 24, ovf=1 with FIFOCTRL_ERRFLAG_EN (0 without).
- DEPTH=24, fill then drain 30 entries with continuous traffic: wraddr and rdaddr wrap 23->0, never reach 24; data order preserved.
- Simultaneous fifowr&fiford:
  - At fifolen=5: both enables=1, fifolen stays 5, rdvalid=1 next cycle.
  - At fifolen=0: read=0, write=1, fifolen becomes 1, udf=1 (macro on).
  - At fifolen=DEPTH: write=0, read=1, fifolen becomes DEPTH-1.
- clr at fifolen=10 asserted together with fifowr and fiford: write=read=0, next cycle fifolen=0, pointers 0, ovf=udf=0.
- rst=0 for one cycle at fifolen=17 with read=1 in the prior cycle: next cycle all state 0 and rdvalid=0.
